car_window_counter: RTL

CAR_WINDOW_COUNTER -- requirements
Module: car_window_counter

---
 rtl/car_window_counter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/car_window_counter.sv
// Car counter: synchronizes and debounces a presence sensor, keeps a saturating
// running total and the car count of the last completed clk_2s-based window.
module car_window_counter #(
  parameter int WIN_TICKS = 30,
  parameter int DEB_CYC   = 1000,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_2s,
  input  logic             car_sensor,
  input  logic             clr,
  output logic [CNT_W-1:0] car_total,
  output logic [CNT_W-1:0] car_rate,
  output logic             rate_valid,
  output logic             car_present
);

  localparam int DEB_W  = $clog2(DEB_CYC + 1);
  localparam int TICK_W = $clog2(WIN_TICKS + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
  localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(WIN_TICKS - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [TICK_W-1:0] TICK_ZERO = TICK_W'(0);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DEB_ON  = 2'd1,
    S_PRESENT = 2'd2,
    S_DEB_OFF = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    if (val == CNT_MAX) begin
      sat_inc = val;
    end else begin
      sat_inc = val + CNT_ONE;
    end
  endfunction

  logic              sens_meta_r, sens_sync_r;
  logic              clk2s_meta_r, clk2s_sync_r, clk2s_prev_r;
  logic [1:0]        arm_r;
  logic              tick_s, win_close_s;
  state_t            state_r, state_nx_s;
  logic [DEB_W-1:0]  deb_cnt_r, deb_cnt_nx_s;
  logic              car_evt_s, car_evt_r;
  logic              car_present_r;
  logic [TICK_W-1:0] tick_cnt_r;
  logic [CNT_W-1:0]  win_cnt_r, car_total_r, car_rate_r;
  logic              rate_valid_r;

  // Input synchronizers, clk_2s edge register and tick arming after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sens_meta_r  <= 1'b0;
      sens_sync_r  <= 1'b0;
      clk2s_meta_r <= 1'b0;
      clk2s_sync_r <= 1'b0;
      clk2s_prev_r <= 1'b0;
      arm_r        <= 2'd0;
    end else begin
      sens_meta_r  <= car_sensor;
      sens_sync_r  <= sens_meta_r;
      clk2s_meta_r <= clk_2s;
      clk2s_sync_r <= clk2s_meta_r;
      clk2s_prev_r <= clk2s_sync_r;
      arm_r        <= (arm_r == 2'd3) ? arm_r : arm_r + 2'd1;
    end
  end

  // The sync chain fills only after release, so a level already high then is not an edge
  assign tick_s      = clk2s_sync_r & ~clk2s_prev_r & (arm_r == 2'd3);
  assign win_close_s = tick_s & (tick_cnt_r == TICK_LAST);

  // Debounce next-state logic
  always_comb begin
    state_nx_s   = state_r;
    deb_cnt_nx_s = deb_cnt_r;
    car_evt_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (sens_sync_r) begin
          state_nx_s   = S_DEB_ON;
          deb_cnt_nx_s = DEB_ONE;
        end else begin
          state_nx_s   = S_IDLE;
        end
      end
      S_DEB_ON: begin
        if (!sens_sync_r) begin
          state_nx_s   = S_IDLE;
        end else if (deb_cnt_r == DEB_LAST) begin
          state_nx_s   = S_PRESENT;
          car_evt_s    = 1'b1;
        end else begin
          deb_cnt_nx_s = deb_cnt_r + DEB_ONE;
        end
      end
      S_PRESENT: begin
        if (!sens_sync_r) begin
          state_nx_s   = S_DEB_OFF;
          deb_cnt_nx_s = DEB_ONE;
        end else begin
          state_nx_s   = S_PRESENT;
        end
      end
      S_DEB_OFF: begin
        if (sens_sync_r) begin
          state_nx_s   = S_PRESENT;
        end else if (deb_cnt_r == DEB_LAST) begin
          state_nx_s   = S_IDLE;
        end else begin
          deb_cnt_nx_s = deb_cnt_r + DEB_ONE;
        end
      end
      default: begin
        state_nx_s   = S_IDLE;
        deb_cnt_nx_s = DEB_W'(0);
      end
    endcase
  end

  // FSM state, registered presence flag and registered car event (clr drops a pending event)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= S_IDLE;
      deb_cnt_r     <= DEB_W'(0);
      car_present_r <= 1'b0;
      car_evt_r     <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      deb_cnt_r     <= deb_cnt_nx_s;
      car_present_r <= (state_nx_s == S_PRESENT) || (state_nx_s == S_DEB_OFF);
      car_evt_r     <= car_evt_s & ~clr;
    end
  end

  // Running total, window count, tick counter and per-window rate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      car_total_r  <= CNT_ZERO;
      win_cnt_r    <= CNT_ZERO;
      tick_cnt_r   <= TICK_ZERO;
      car_rate_r   <= CNT_ZERO;
      rate_valid_r <= 1'b0;
    end else if (clr) begin
      car_total_r  <= CNT_ZERO;
      win_cnt_r    <= CNT_ZERO;
      tick_cnt_r   <= TICK_ZERO;
      car_rate_r   <= CNT_ZERO;
      rate_valid_r <= 1'b0;
    end else begin
      car_total_r <= car_evt_r ? sat_inc(car_total_r) : car_total_r;
      if (win_close_s) begin
        // A car landing on the closing cycle belongs to the new window
        car_rate_r   <= win_cnt_r;
        rate_valid_r <= 1'b1;
        tick_cnt_r   <= TICK_ZERO;
        win_cnt_r    <= car_evt_r ? CNT_ONE : CNT_ZERO;
      end else begin
        rate_valid_r <= 1'b0;
        tick_cnt_r   <= tick_s ? tick_cnt_r + TICK_ONE : tick_cnt_r;
        win_cnt_r    <= car_evt_r ? sat_inc(win_cnt_r) : win_cnt_r;
      end
    end
  end

  assign car_total   = car_total_r;
  assign car_rate    = car_rate_r;
  assign rate_valid  = rate_valid_r;
  assign car_present = car_present_r;

endmodule
